// File: rtl/ipbus_ctrl_reg_slave_pkg.sv
// ipbus_ctrl_reg_slave_pkg
//   Shared constants for the IPbus control/status register slave: address map,
//   command bit positions, timestamp word indices and FSM state encoding.
package ipbus_ctrl_reg_slave_pkg;

    // Address map (word addresses)
    localparam logic [5:0] STATUS_BASE = 6'h00;
    localparam logic [5:0] CTRL0_ADDR  = 6'h20;
    localparam logic [5:0] CTRL1_ADDR  = 6'h21;
    localparam logic [5:0] THRES0_ADDR = 6'h22;  // thres_data_corrupt
    localparam logic [5:0] THRES1_ADDR = 6'h23;  // thres_unknown_ttc
    localparam logic [5:0] THRES2_ADDR = 6'h24;  // thres_ddr3_overflow
    localparam logic [5:0] CMD_ADDR    = 6'h25;

    // CMD register bit indices
    localparam int unsigned CMD_RST_ERRORS_BIT   = 0;
    localparam int unsigned CMD_RST_COUNTERS_BIT = 1;

    // Timestamp pair: reading the low word freezes the high word into a shadow
    localparam logic [5:0] TS_LO_IDX = 6'd11;
    localparam logic [5:0] TS_HI_IDX = 6'd12;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StResp = 2'd1,
        StGap  = 2'd2
    } ipb_state_e;

endpackage

// File: rtl/ipbus_ctrl_reg_slave.sv
// ipbus_ctrl_reg_slave
//   IPbus slave for the status/control register space. Status words are read
//   through a registered mux; control registers drive thresholds, channel
//   enable, trigger configuration and endianness; CMD writes yield one-cycle
//   pulses. One transaction per three cycles (IDLE -> RESP -> GAP).
// Ports
//   clk, reset             : clock, synchronous active-high reset
//   ipb_strobe/write/addr/wdata : IPbus request
//   ipb_rdata/ack/err      : IPbus response (valid in the RESP cycle)
//   status_bus             : N_STATUS packed 32-bit status words
//   thres_*, chan_en, trig_delay, trig_settings, endianness_sel : control outputs
//   rst_errors_pulse, rst_counters_pulse : single-cycle command pulses
module ipbus_ctrl_reg_slave
    import ipbus_ctrl_reg_slave_pkg::*;
#(
    parameter int unsigned N_STATUS        = 19,
    parameter logic [4:0]  CHAN_EN_DEFAULT = 5'h1F,
    parameter logic [31:0] THRES_DEFAULT   = 32'hFFFF_FFFF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ipb_strobe,
    input  logic                    ipb_write,
    input  logic [5:0]              ipb_addr,
    input  logic [31:0]             ipb_wdata,
    output logic [31:0]             ipb_rdata,
    output logic                    ipb_ack,
    output logic                    ipb_err,
    input  logic [32*N_STATUS-1:0]  status_bus,
    output logic [31:0]             thres_data_corrupt,
    output logic [31:0]             thres_unknown_ttc,
    output logic [31:0]             thres_ddr3_overflow,
    output logic [4:0]              chan_en,
    output logic [3:0]              trig_delay,
    output logic [7:0]              trig_settings,
    output logic                    endianness_sel,
    output logic                    rst_errors_pulse,
    output logic                    rst_counters_pulse
);

    localparam logic [6:0] NStatusW = 7'(N_STATUS);

    // Full 64-entry view of the status space so the 6-bit address indexes it
    // directly; entries beyond N_STATUS read as zero but are never selected.
    logic [31:0] status_w [64];
    for (genvar k = 0; k < 64; k++) begin : g_status
        if (k < N_STATUS) begin : g_live
            assign status_w[k] = status_bus[32*k +: 32];
        end else begin : g_none
            assign status_w[k] = 32'd0;
        end
    end

    ipb_state_e  state_q, state_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] shadow_q, shadow_d;
    logic [31:0] thres0_q, thres0_d;
    logic [31:0] thres1_q, thres1_d;
    logic [31:0] thres2_q, thres2_d;
    logic [4:0]  chan_en_q, chan_en_d;
    logic [3:0]  trig_delay_q, trig_delay_d;
    logic [7:0]  trig_settings_q, trig_settings_d;
    logic        endian_q, endian_d;
    logic        pulse_err_q, pulse_err_d;
    logic        pulse_cnt_q, pulse_cnt_d;

    logic        is_status;
    logic        hit;

    assign is_status = ({1'b0, ipb_addr} - {1'b0, STATUS_BASE}) < NStatusW;

    always_comb begin
        state_d         = state_q;
        ack_d           = 1'b0;
        err_d           = 1'b0;
        rdata_d         = rdata_q;
        shadow_d        = shadow_q;
        thres0_d        = thres0_q;
        thres1_d        = thres1_q;
        thres2_d        = thres2_q;
        chan_en_d       = chan_en_q;
        trig_delay_d    = trig_delay_q;
        trig_settings_d = trig_settings_q;
        endian_d        = endian_q;
        pulse_err_d     = 1'b0;
        pulse_cnt_d     = 1'b0;
        hit             = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (ipb_strobe) begin
                    state_d = StResp;
                    rdata_d = 32'd0;
                    if (ipb_write) begin
                        // Status words are read-only: a write there is an error
                        if (!is_status) begin
                            hit = 1'b1;
                            case (ipb_addr)
                                CTRL0_ADDR: begin
                                    endian_d     = ipb_wdata[12];
                                    trig_delay_d = ipb_wdata[11:8];
                                    chan_en_d    = ipb_wdata[4:0];
                                end
                                CTRL1_ADDR:  trig_settings_d = ipb_wdata[7:0];
                                THRES0_ADDR: thres0_d = ipb_wdata;
                                THRES1_ADDR: thres1_d = ipb_wdata;
                                THRES2_ADDR: thres2_d = ipb_wdata;
                                CMD_ADDR: begin
                                    pulse_err_d = ipb_wdata[CMD_RST_ERRORS_BIT];
                                    pulse_cnt_d = ipb_wdata[CMD_RST_COUNTERS_BIT];
                                end
                                default: hit = 1'b0;
                            endcase
                        end
                    end else begin
                        hit = 1'b1;
                        if (is_status) begin
                            if (ipb_addr == TS_HI_IDX) begin
                                rdata_d = shadow_q;
                            end else begin
                                rdata_d = status_w[ipb_addr];
                            end
                            // Freeze the high timestamp word alongside the low one
                            if (ipb_addr == TS_LO_IDX) begin
                                shadow_d = status_w[TS_HI_IDX];
                            end
                        end else begin
                            case (ipb_addr)
                                CTRL0_ADDR:  rdata_d = {19'd0, endian_q, trig_delay_q,
                                                        3'd0, chan_en_q};
                                CTRL1_ADDR:  rdata_d = {24'd0, trig_settings_q};
                                THRES0_ADDR: rdata_d = thres0_q;
                                THRES1_ADDR: rdata_d = thres1_q;
                                THRES2_ADDR: rdata_d = thres2_q;
                                CMD_ADDR:    rdata_d = 32'd0;
                                default:     hit = 1'b0;
                            endcase
                        end
                    end
                    ack_d = hit;
                    err_d = !hit;
                end
            end
            StResp:  state_d = StGap;
            StGap:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StIdle;
            ack_q           <= 1'b0;
            err_q           <= 1'b0;
            rdata_q         <= 32'd0;
            shadow_q        <= 32'd0;
            thres0_q        <= THRES_DEFAULT;
            thres1_q        <= THRES_DEFAULT;
            thres2_q        <= THRES_DEFAULT;
            chan_en_q       <= CHAN_EN_DEFAULT;
            trig_delay_q    <= 4'd0;
            trig_settings_q <= 8'd0;
            endian_q        <= 1'b0;
            pulse_err_q     <= 1'b0;
            pulse_cnt_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            ack_q           <= ack_d;
            err_q           <= err_d;
            rdata_q         <= rdata_d;
            shadow_q        <= shadow_d;
            thres0_q        <= thres0_d;
            thres1_q        <= thres1_d;
            thres2_q        <= thres2_d;
            chan_en_q       <= chan_en_d;
            trig_delay_q    <= trig_delay_d;
            trig_settings_q <= trig_settings_d;
            endian_q        <= endian_d;
            pulse_err_q     <= pulse_err_d;
            pulse_cnt_q     <= pulse_cnt_d;
        end
    end

    assign ipb_rdata           = rdata_q;
    assign ipb_ack             = ack_q;
    assign ipb_err             = err_q;
    assign thres_data_corrupt  = thres0_q;
    assign thres_unknown_ttc   = thres1_q;
    assign thres_ddr3_overflow = thres2_q;
    assign chan_en             = chan_en_q;
    assign trig_delay          = trig_delay_q;
    assign trig_settings       = trig_settings_q;
    assign endianness_sel      = endian_q;
    assign rst_errors_pulse    = pulse_err_q;
    assign rst_counters_pulse  = pulse_cnt_q;

endmodule

// File: tb/tb_ipbus_ctrl_reg_slave.sv
// tb_ipbus_ctrl_reg_slave
//   Directed, table-driven bench for ipbus_ctrl_reg_slave plus hand-written
//   sequences for timestamp coherency, back-to-back strobes and reset cases.
module tb_ipbus_ctrl_reg_slave;

    localparam int unsigned NS = 19;

    logic              clk = 1'b0;
    logic              reset;
    logic              ipb_strobe;
    logic              ipb_write;
    logic [5:0]        ipb_addr;
    logic [31:0]       ipb_wdata;
    logic [31:0]       ipb_rdata;
    logic              ipb_ack;
    logic              ipb_err;
    logic [32*NS-1:0]  status_bus;
    logic [31:0]       thres_data_corrupt, thres_unknown_ttc, thres_ddr3_overflow;
    logic [4:0]        chan_en;
    logic [3:0]        trig_delay;
    logic [7:0]        trig_settings;
    logic              endianness_sel;
    logic              rst_errors_pulse, rst_counters_pulse;

    logic [31:0] stat [NS];

    always_comb begin
        for (int k = 0; k < NS; k++) begin
            status_bus[32*k +: 32] = stat[k];
        end
    end

    always #5 clk = ~clk;

    ipbus_ctrl_reg_slave #(
        .N_STATUS        (NS),
        .CHAN_EN_DEFAULT (5'h1F),
        .THRES_DEFAULT   (32'hFFFF_FFFF)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .ipb_strobe          (ipb_strobe),
        .ipb_write           (ipb_write),
        .ipb_addr            (ipb_addr),
        .ipb_wdata           (ipb_wdata),
        .ipb_rdata           (ipb_rdata),
        .ipb_ack             (ipb_ack),
        .ipb_err             (ipb_err),
        .status_bus          (status_bus),
        .thres_data_corrupt  (thres_data_corrupt),
        .thres_unknown_ttc   (thres_unknown_ttc),
        .thres_ddr3_overflow (thres_ddr3_overflow),
        .chan_en             (chan_en),
        .trig_delay          (trig_delay),
        .trig_settings       (trig_settings),
        .endianness_sel      (endianness_sel),
        .rst_errors_pulse    (rst_errors_pulse),
        .rst_counters_pulse  (rst_counters_pulse)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [4:0]  exp_chan;
        logic [3:0]  exp_td;
        logic [7:0]  exp_ts;
        logic        exp_end;
        logic [31:0] exp_t0;
        logic [31:0] exp_t1;
        logic [31:0] exp_t2;
        logic [1:0]  exp_pulse;  // {rst_counters, rst_errors}
    } vec_t;

    vec_t vecs[$];

    // One transaction: strobe sampled at the next posedge, response sampled in
    // RESP, then one GAP cycle. Leaves the bench at the GAP negedge.
    task automatic xact(input logic wr, input logic [5:0] addr, input logic [31:0] wdata,
                        output logic ack, output logic err, output logic [31:0] rdata,
                        output logic [1:0] pulse, output logic gap_busy,
                        output logic [31:0] gap_rdata);
        @(negedge clk);
        ipb_strobe = 1'b1;
        ipb_write  = wr;
        ipb_addr   = addr;
        ipb_wdata  = wdata;
        @(negedge clk);
        ack   = ipb_ack;
        err   = ipb_err;
        rdata = ipb_rdata;
        pulse = {rst_counters_pulse, rst_errors_pulse};
        ipb_strobe = 1'b0;
        @(negedge clk);
        gap_busy  = ipb_ack | ipb_err | rst_counters_pulse | rst_errors_pulse;
        gap_rdata = ipb_rdata;
    endtask

    logic        a, e, gb;
    logic [31:0] rd, grd;
    logic [1:0]  pl;
    logic        ack_hist [10];

    initial begin
        for (int k = 0; k < NS; k++) stat[k] = 32'hA500_0000 + 32'(k) * 32'h0101;
        ipb_strobe = 1'b0;
        ipb_write  = 1'b0;
        ipb_addr   = 6'd0;
        ipb_wdata  = 32'd0;

        // Reset held with a coincident write strobe: reset must win
        reset      = 1'b1;
        ipb_strobe = 1'b1;
        ipb_write  = 1'b1;
        ipb_addr   = 6'h20;
        ipb_wdata  = 32'h0000_0000;
        repeat (3) @(negedge clk);
        chk("reset ack", 32'(ipb_ack), 32'd0);
        chk("reset err", 32'(ipb_err), 32'd0);
        chk("reset rdata", ipb_rdata, 32'd0);
        chk("reset chan_en", 32'(chan_en), 32'h1F);
        chk("reset thres0", thres_data_corrupt, 32'hFFFF_FFFF);
        chk("reset thres1", thres_unknown_ttc, 32'hFFFF_FFFF);
        chk("reset thres2", thres_ddr3_overflow, 32'hFFFF_FFFF);
        chk("reset ctrl misc", {19'd0, endianness_sel, trig_delay, trig_settings}, 32'd0);
        chk("reset pulses", 32'({rst_counters_pulse, rst_errors_pulse}), 32'd0);
        ipb_strobe = 1'b0;
        reset      = 1'b0;

        //        wr    addr   wdata          err  rdata          chan   td    ts     en  t0             t1             t2             pulse
        vecs.push_back('{1'b0, 6'h20, 32'h0,         1'b0, 32'h0000_001F, 5'h1F, 4'h0, 8'h00, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00});
        vecs.push_back('{1'b0, 6'h22, 32'h0,         1'b0, 32'hFFFF_FFFF, 5'h1F, 4'h0, 8'h00, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00});
        vecs.push_back('{1'b0, 6'h0C, 32'h0,         1'b0, 32'h0000_0000, 5'h1F, 4'h0, 8'h00, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00});
        vecs.push_back('{1'b1, 6'h20, 32'hFFFF_FA15, 1'b0, 32'h0000_0000, 5'h15, 4'hA, 8'h00, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00});
        vecs.push_back('{1'b0, 6'h20, 32'h0,         1'b0, 32'h0000_1A15, 5'h15, 4'hA, 8'h00, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00});
        vecs.push_back('{1'b1, 6'h21, 32'hABCD_12C3, 1'b0, 32'h0000_0000, 5'h15, 4'hA, 8'hC3, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00});
        vecs.push_back('{1'b0, 6'h21, 32'h0,         1'b0, 32'h0000_00C3, 5'h15, 4'hA, 8'hC3, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00});
        vecs.push_back('{1'b1, 6'h23, 32'h1234_5678, 1'b0, 32'h0000_0000, 5'h15, 4'hA, 8'hC3, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF, 2'b00});
        vecs.push_back('{1'b0, 6'h23, 32'h0,         1'b0, 32'h1234_5678, 5'h15, 4'hA, 8'hC3, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF, 2'b00});
        vecs.push_back('{1'b1, 6'h25, 32'h0000_0003, 1'b0, 32'h0000_0000, 5'h15, 4'hA, 8'hC3, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF, 2'b11});
        vecs.push_back('{1'b0, 6'h25, 32'h0,         1'b0, 32'h0000_0000, 5'h15, 4'hA, 8'hC3, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF, 2'b00});
        vecs.push_back('{1'b1, 6'h25, 32'h0000_0002, 1'b0, 32'h0000_0000, 5'h15, 4'hA, 8'hC3, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF, 2'b10});
        vecs.push_back('{1'b1, 6'h25, 32'h0000_0001, 1'b0, 32'h0000_0000, 5'h15, 4'hA, 8'hC3, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF, 2'b01});
        vecs.push_back('{1'b1, 6'h25, 32'h0000_0000, 1'b0, 32'h0000_0000, 5'h15, 4'hA, 8'hC3, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF, 2'b00});
        vecs.push_back('{1'b0, 6'h12, 32'h0,         1'b0, 32'hA500_1212, 5'h15, 4'hA, 8'hC3, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF, 2'b00});
        vecs.push_back('{1'b1, 6'h05, 32'hDEAD_BEEF, 1'b1, 32'h0000_0000, 5'h15, 4'hA, 8'hC3, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF, 2'b00});
        vecs.push_back('{1'b0, 6'h30, 32'h0,         1'b1, 32'h0000_0000, 5'h15, 4'hA, 8'hC3, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF, 2'b00});
        vecs.push_back('{1'b0, 6'h13, 32'h0,         1'b1, 32'h0000_0000, 5'h15, 4'hA, 8'hC3, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF, 2'b00});
        vecs.push_back('{1'b1, 6'h26, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 5'h15, 4'hA, 8'hC3, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF, 2'b00});
        vecs.push_back('{1'b1, 6'h12, 32'h0000_0000, 1'b1, 32'h0000_0000, 5'h15, 4'hA, 8'hC3, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF, 2'b00});
        vecs.push_back('{1'b0, 6'h00, 32'h0,         1'b0, 32'hA500_0000, 5'h15, 4'hA, 8'hC3, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF, 2'b00});
        vecs.push_back('{1'b0, 6'h0B, 32'h0,         1'b0, 32'hA500_0B0B, 5'h15, 4'hA, 8'hC3, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF, 2'b00});
        vecs.push_back('{1'b0, 6'h0C, 32'h0,         1'b0, 32'hA500_0C0C, 5'h15, 4'hA, 8'hC3, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF, 2'b00});
        vecs.push_back('{1'b1, 6'h22, 32'h0000_0000, 1'b0, 32'h0000_0000, 5'h15, 4'hA, 8'hC3, 1'b1, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 2'b00});
        vecs.push_back('{1'b1, 6'h24, 32'hCAFE_F00D, 1'b0, 32'h0000_0000, 5'h15, 4'hA, 8'hC3, 1'b1, 32'h0000_0000, 32'h1234_5678, 32'hCAFE_F00D, 2'b00});
        vecs.push_back('{1'b0, 6'h24, 32'h0,         1'b0, 32'hCAFE_F00D, 5'h15, 4'hA, 8'hC3, 1'b1, 32'h0000_0000, 32'h1234_5678, 32'hCAFE_F00D, 2'b00});

        foreach (vecs[i]) begin
            xact(vecs[i].wr, vecs[i].addr, vecs[i].wdata, a, e, rd, pl, gb, grd);
            chk($sformatf("v%0d ack", i), 32'(a), 32'(!vecs[i].exp_err));
            chk($sformatf("v%0d err", i), 32'(e), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("v%0d pulse", i), 32'(pl), 32'(vecs[i].exp_pulse));
            chk($sformatf("v%0d gap quiet", i), 32'(gb), 32'd0);
            chk($sformatf("v%0d gap rdata held", i), grd, vecs[i].exp_rdata);
            chk($sformatf("v%0d ctrl", i),
                {15'd0, endianness_sel, trig_delay, trig_settings, chan_en},
                {15'd0, vecs[i].exp_end, vecs[i].exp_td, vecs[i].exp_ts, vecs[i].exp_chan});
            chk($sformatf("v%0d thres0", i), thres_data_corrupt, vecs[i].exp_t0);
            chk($sformatf("v%0d thres1", i), thres_unknown_ttc, vecs[i].exp_t1);
            chk($sformatf("v%0d thres2", i), thres_ddr3_overflow, vecs[i].exp_t2);
        end

        // Timestamp coherency and rdata hold against live status changes
        stat[11] = 32'h1111_1111;
        stat[12] = 32'h0000_0ABC;
        @(negedge clk);
        ipb_strobe = 1'b1;
        ipb_write  = 1'b0;
        ipb_addr   = 6'h0B;
        @(negedge clk);
        chk("ts lo rdata", ipb_rdata, 32'h1111_1111);
        ipb_strobe = 1'b0;
        stat[11]   = 32'h2222_2222;
        @(negedge clk);
        chk("ts lo rdata held", ipb_rdata, 32'h1111_1111);
        stat[12] = 32'h0000_0DEF;
        xact(1'b0, 6'h0C, 32'h0, a, e, rd, pl, gb, grd);
        chk("ts hi shadow ack", 32'(a), 32'd1);
        chk("ts hi shadow rdata", rd, 32'h0000_0ABC);

        // Strobe held continuously: acks every third cycle
        @(negedge clk);
        ipb_strobe = 1'b1;
        ipb_write  = 1'b0;
        ipb_addr   = 6'h20;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            ack_hist[c] = ipb_ack;
        end
        ipb_strobe = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            chk($sformatf("b2b ack c%0d", c), 32'(ack_hist[c]),
                32'((c == 1) || (c == 4) || (c == 7)));
        end

        // Held write strobe with reset asserted over the second sample
        ipb_strobe = 1'b1;
        ipb_write  = 1'b1;
        ipb_addr   = 6'h21;
        ipb_wdata  = 32'h0000_005A;
        @(negedge clk);
        chk("rst-hold ack1", 32'(ipb_ack), 32'd1);
        chk("rst-hold ts1", 32'(trig_settings), 32'h5A);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst-hold no ack", 32'({ipb_ack, ipb_err}), 32'd0);
        chk("rst-hold ts reset", 32'(trig_settings), 32'h00);
        chk("rst-hold chan reset", 32'(chan_en), 32'h1F);
        reset = 1'b0;
        @(negedge clk);
        chk("rst-hold ack after release", 32'(ipb_ack), 32'd1);
        chk("rst-hold ts after release", 32'(trig_settings), 32'h5A);
        ipb_strobe = 1'b0;

        // Reset during RESP drops the response and returns straight to IDLE
        @(negedge clk);
        @(negedge clk);
        ipb_strobe = 1'b1;
        ipb_write  = 1'b0;
        ipb_addr   = 6'h21;
        @(negedge clk);
        chk("rst-resp ack before", 32'(ipb_ack), 32'd1);
        chk("rst-resp rdata before", ipb_rdata, 32'h0000_005A);
        reset      = 1'b1;
        ipb_strobe = 1'b0;
        @(negedge clk);
        chk("rst-resp ack dropped", 32'({ipb_ack, ipb_err}), 32'd0);
        chk("rst-resp rdata cleared", ipb_rdata, 32'd0);
        reset      = 1'b0;
        ipb_strobe = 1'b1;
        @(negedge clk);
        chk("rst-resp idle ack", 32'(ipb_ack), 32'd1);
        chk("rst-resp idle rdata", ipb_rdata, 32'd0);
        ipb_strobe = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
